// File: rtl/mmcm_drp_ctrl_if.sv
// Command and DRP bus bundle for the MMCM reconfiguration controller.
// master = controller side, slave = command source plus DRP port.
interface mmcm_drp_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_mask;
    logic [15:0] cmd_data;
    logic        cmd_last;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_last,
        input  drp_do, drp_drdy,
        output cmd_ready, drp_daddr, drp_den, drp_dwe, drp_di
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_last,
        output drp_do, drp_drdy,
        input  cmd_ready, drp_daddr, drp_den, drp_dwe, drp_di
    );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// MMCM DRP reconfiguration controller: read-modify-write sequences
// under MMCM reset, lock supervision and loss-of-lock recovery.
module mmcm_drp_ctrl #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 255
) (
    input  logic        clk_100,
    input  logic        reset,
    mmcm_drp_ctrl_if.master bus,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        locked_sync,
    output logic        lock_lost
);

    localparam int MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int MAX_L = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
    localparam int CW    = $clog2(MAX_L + 1);

    localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRDY_LIM = CW'(DRDY_TIMEOUT);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        POR_HOLD,
        IDLE,
        RST_ASSERT,
        WAIT_CMD,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        RST_HOLD2,
        WAIT_LOCK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_lim;
    logic          sync1;
    logic          locked_prev;
    logic [6:0]    addr_q;
    logic [15:0]   mask_q;
    logic [15:0]   data_q;
    logic          last_q;
    logic [15:0]   di_q;
    logic          den_q;
    logic          dwe_q;
    logic          rst_q;
    logic          lost_q;
    logic          accept;
    logic          rd_cap;
    logic          start;
    logic          lost_det;
    logic [1:0]    err_val;

    // One shared counter; its ceiling depends on what the state waits for
    always_comb begin
        cnt_lim = '0;
        unique case (state)
            POR_HOLD, RST_ASSERT, RST_HOLD2: cnt_lim = HOLD_END;
            RD_WAIT, WR_WAIT:                cnt_lim = DRDY_LIM;
            WAIT_LOCK:                       cnt_lim = LOCK_LIM;
            default:                         cnt_lim = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        err       = 1'b0;
        err_val   = 2'd0;
        accept    = 1'b0;
        rd_cap    = 1'b0;
        start     = 1'b0;
        lost_det  = 1'b0;
        unique case (state)
            POR_HOLD, RST_HOLD2: begin
                if (cnt == HOLD_END) state_nxt = WAIT_LOCK;
            end
            IDLE: begin
                if (locked_prev && !locked_sync) begin
                    lost_det  = 1'b1;
                    state_nxt = RST_HOLD2;
                end else if (bus.cmd_valid) begin
                    start     = 1'b1;
                    state_nxt = RST_ASSERT;
                end
            end
            RST_ASSERT: begin
                if (cnt == HOLD_END) state_nxt = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = RD;
                end
            end
            RD: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (bus.drp_drdy) begin
                    rd_cap    = 1'b1;
                    state_nxt = WR;
                end else if (cnt == DRDY_LIM) begin
                    err       = 1'b1;
                    err_val   = 2'd2;
                    state_nxt = IDLE;
                end
            end
            WR: state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (bus.drp_drdy) begin
                    state_nxt = last_q ? WAIT_LOCK : WAIT_CMD;
                end else if (cnt == DRDY_LIM) begin
                    err       = 1'b1;
                    err_val   = 2'd2;
                    state_nxt = IDLE;
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == LOCK_LIM) begin
                    err       = 1'b1;
                    err_val   = 2'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = POR_HOLD;
        endcase
    end

    // MMCM/DRP strobes are registered from the next state to stay glitch-free
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state       <= POR_HOLD;
            cnt         <= '0;
            sync1       <= 1'b0;
            locked_sync <= 1'b0;
            locked_prev <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            di_q        <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            rst_q       <= 1'b1;
            err_code    <= 2'd0;
            lost_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (cnt != cnt_lim) cnt <= cnt + 1'b1;
            sync1       <= mmcm_locked;
            locked_sync <= sync1;
            locked_prev <= locked_sync;
            if (accept) begin
                addr_q <= bus.cmd_addr;
                mask_q <= bus.cmd_mask;
                data_q <= bus.cmd_data;
                last_q <= bus.cmd_last;
            end
            if (rd_cap) di_q <= (bus.drp_do & mask_q) | (data_q & ~mask_q);
            den_q <= (state_nxt == RD) || (state_nxt == WR);
            dwe_q <= (state_nxt == WR);
            rst_q <= !((state_nxt == IDLE) || (state_nxt == WAIT_LOCK));
            if (start) err_code <= 2'd0;
            else if (err) err_code <= err_val;
            lost_q <= lost_det;
        end
    end

    assign bus.cmd_ready = (state == WAIT_CMD);
    assign bus.drp_daddr = addr_q;
    assign bus.drp_den   = den_q;
    assign bus.drp_dwe   = dwe_q;
    assign bus.drp_di    = di_q;
    assign mmcm_rst      = rst_q;
    assign busy          = (state != IDLE);
    assign lock_lost     = lost_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with DRP register and MMCM lock models.
// Lock asserts 20 cycles after mmcm_rst falls; DRDY follows DEN by drdy_lat.
module tb_mmcm_drp_ctrl;

    logic       clk_100 = 1'b0;
    logic       reset = 1'b1;
    logic       mmcm_rst;
    logic       mmcm_locked = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       locked_sync;
    logic       lock_lost;

    mmcm_drp_ctrl_if bus ();

    mmcm_drp_ctrl #(
        .RST_HOLD    (16),
        .LOCK_TIMEOUT(100),
        .DRDY_TIMEOUT(255)
    ) dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .bus        (bus),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .locked_sync(locked_sync),
        .lock_lost  (lock_lost)
    );

    always #5 clk_100 = ~clk_100;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk_100) cyc <= cyc + 1;

    // lock model: 0 follows mmcm_rst, 1 forced low, 2 forced high
    int lock_mode = 0;
    int lcnt = 0;
    int lock_at = -100;

    always @(negedge clk_100) begin
        case (lock_mode)
            1: begin
                mmcm_locked = 1'b0;
                lcnt = 0;
            end
            2: mmcm_locked = 1'b1;
            default: begin
                if (mmcm_rst !== 1'b0) begin
                    mmcm_locked = 1'b0;
                    lcnt = 0;
                end else if (!mmcm_locked) begin
                    lcnt++;
                    if (lcnt == 20) begin
                        mmcm_locked = 1'b1;
                        lock_at = cyc;
                    end
                end
            end
        endcase
    end

    logic [15:0] mem [128];
    logic [6:0]  wl_addr [8];
    logic [15:0] wl_data [8];
    int rsp_cnt = 0;
    bit rsp_fire = 0;
    bit drdy_en = 1;
    bit stray_req = 0;
    int drdy_lat = 3;
    int wcount = 0;
    int rcount = 0;
    bit drp_rst_low = 0;
    int ll_count = 0;

    always @(negedge clk_100) begin
        if (rsp_fire) begin
            bus.drp_drdy = 1'b0;
            rsp_fire = 0;
        end
        if (stray_req) begin
            bus.drp_drdy = 1'b1;
            rsp_fire = 1;
            stray_req = 0;
        end
        if (rsp_cnt != 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.drp_drdy = 1'b1;
                rsp_fire = 1;
            end
        end
        if (bus.drp_den === 1'b1) begin
            if (mmcm_rst !== 1'b1) drp_rst_low = 1;
            if (bus.drp_dwe === 1'b1) begin
                mem[bus.drp_daddr] = bus.drp_di;
                if (wcount < 8) begin
                    wl_addr[wcount] = bus.drp_daddr;
                    wl_data[wcount] = bus.drp_di;
                end
                wcount++;
            end else begin
                bus.drp_do = mem[bus.drp_daddr];
                rcount++;
            end
            if (drdy_en) rsp_cnt = drdy_lat;
        end
    end

    always @(negedge clk_100) if (lock_lost === 1'b1) ll_count++;

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] m,
                            input logic [15:0] d, input logic l, output bit ok);
        int n;
        bus.cmd_addr = a;
        bus.cmd_mask = m;
        bus.cmd_data = d;
        bus.cmd_last = l;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk_100);
            n++;
        end
        ok = (bus.cmd_ready === 1'b1);
        @(negedge clk_100);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clk_100);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic count_rst_high(output int n);
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_100);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_100);
        checks++;
        if ({mmcm_rst, bus.drp_den, bus.drp_dwe, bus.cmd_ready, busy,
             done, err, lock_lost, locked_sync} !== 9'b1_0001_0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b%b%b expected 100010000",
                     mmcm_rst, bus.drp_den, bus.drp_dwe, bus.cmd_ready, busy,
                     done, err, lock_lost, locked_sync);
        end
        checks++;
        if (bus.drp_daddr !== 7'd0 || bus.drp_di !== 16'd0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: daddr=%h di=%h code=%0d expected 0 0 0",
                     bus.drp_daddr, bus.drp_di, err_code);
        end
    endtask

    task automatic test_por;
        int n;
        bit ok;
        reset = 1'b0;
        count_rst_high(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL por_rst_len: got %0d expected 16", n);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || cyc !== lock_at + 2) begin
            failures++;
            $display("FAIL por_done: ok=%0d at %0d expected %0d", ok, cyc, lock_at + 2);
        end
        @(negedge clk_100);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || locked_sync !== 1'b1) begin
            failures++;
            $display("FAIL por_idle: busy=%b done=%b lsync=%b expected 0 0 1",
                     busy, done, locked_sync);
        end
    endtask

    task automatic test_rmw;
        bit ok1, ok2, ok;
        int ll0;
        ll0 = ll_count;
        mem[8] = 16'h1245;
        mem[9] = 16'h0080;
        wcount = 0;
        rcount = 0;
        drp_rst_low = 0;
        send_cmd(7'h08, 16'hF000, 16'h0C3C, 1'b0, ok1);
        send_cmd(7'h09, 16'hFF00, 16'h0000, 1'b1, ok2);
        checks++;
        if (!ok1 || !ok2) begin
            failures++;
            $display("FAIL rmw_accept: got %0d%0d expected 11", ok1, ok2);
        end
        wait_done(300, ok);
        checks++;
        if (!ok || cyc !== lock_at + 2) begin
            failures++;
            $display("FAIL rmw_done: ok=%0d at %0d expected %0d", ok, cyc, lock_at + 2);
        end
        checks++;
        if (rcount !== 2 || wcount !== 2) begin
            failures++;
            $display("FAIL rmw_count: rd=%0d wr=%0d expected 2 2", rcount, wcount);
        end
        checks++;
        if (wl_addr[0] !== 7'h08 || wl_data[0] !== 16'h1C3C) begin
            failures++;
            $display("FAIL rmw_wr0: %h=%h expected 08=1c3c", wl_addr[0], wl_data[0]);
        end
        checks++;
        if (wl_addr[1] !== 7'h09 || wl_data[1] !== 16'h0000) begin
            failures++;
            $display("FAIL rmw_wr1: %h=%h expected 09=0000", wl_addr[1], wl_data[1]);
        end
        checks++;
        if (drp_rst_low !== 1'b0 || ll_count !== ll0) begin
            failures++;
            $display("FAIL rmw_rst: rst_low=%0d lock_lost=%0d expected 0 %0d",
                     drp_rst_low, ll_count, ll0);
        end
        @(negedge clk_100);
    endtask

    task automatic test_lock_loss;
        int n, c, ll0;
        bit ok;
        ll0 = ll_count;
        @(posedge clk_100);
        lock_mode = 1;
        @(negedge clk_100);
        c = cyc;
        n = 0;
        while (lock_lost !== 1'b1 && n < 10) begin
            @(negedge clk_100);
            n++;
        end
        checks++;
        if (lock_lost !== 1'b1 || cyc - c !== 3) begin
            failures++;
            $display("FAIL lost_pulse: seen=%b after %0d expected 1 after 3",
                     lock_lost, cyc - c);
        end
        lock_mode = 0;
        count_rst_high(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL lost_rst_len: got %0d expected 16", n);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || cyc !== lock_at + 2) begin
            failures++;
            $display("FAIL lost_done: ok=%0d at %0d expected %0d", ok, cyc, lock_at + 2);
        end
        @(negedge clk_100);
        checks++;
        if (ll_count !== ll0 + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL lost_count: pulses=%0d busy=%b expected %0d 0",
                     ll_count - ll0, busy, 1);
        end
    endtask

    task automatic test_lock_drop_wait_cmd;
        int n, ll0;
        bit ok;
        logic ls_hi;
        ll0 = ll_count;
        mem[10] = 16'hBEEF;
        wcount = 0;
        bus.cmd_valid = 1'b1;
        @(negedge clk_100);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk_100);
            n++;
        end
        @(posedge clk_100);
        lock_mode = 2;
        repeat (5) @(negedge clk_100);
        ls_hi = locked_sync;
        @(posedge clk_100);
        lock_mode = 0;
        repeat (6) @(negedge clk_100);
        @(posedge clk_100);
        stray_req = 1;
        repeat (3) @(negedge clk_100);
        checks++;
        if (ls_hi !== 1'b1 || locked_sync !== 1'b0) begin
            failures++;
            $display("FAIL wc_sync: hi=%b lo=%b expected 1 0", ls_hi, locked_sync);
        end
        checks++;
        if (ll_count !== ll0) begin
            failures++;
            $display("FAIL wc_no_lost: pulses=%0d expected 0", ll_count - ll0);
        end
        checks++;
        if ({bus.cmd_ready, bus.drp_den, busy} !== 3'b101) begin
            failures++;
            $display("FAIL wc_stray: ready/den/busy=%b%b%b expected 101",
                     bus.cmd_ready, bus.drp_den, busy);
        end
        send_cmd(7'h0A, 16'hFFFF, 16'h1234, 1'b1, ok);
        wait_done(300, ok);
        checks++;
        if (!ok || wcount !== 1 || wl_data[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL wc_keep: ok=%0d wr=%0d data=%h expected 1 1 beef",
                     ok, wcount, wl_data[0]);
        end
        @(negedge clk_100);
    endtask

    task automatic test_drdy_timeout;
        int n, c, r0, w0;
        bit ok;
        logic seen_ready;
        r0 = rcount;
        w0 = wcount;
        drdy_en = 0;
        send_cmd(7'h08, 16'h0000, 16'h5555, 1'b0, ok);
        n = 0;
        while (bus.drp_den !== 1'b1 && n < 10) begin
            @(negedge clk_100);
            n++;
        end
        c = cyc;
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            @(negedge clk_100);
            n++;
        end
        checks++;
        if (err !== 1'b1 || cyc - c !== 256) begin
            failures++;
            $display("FAIL drdy_to_time: err=%b after %0d expected 1 after 256",
                     err, cyc - c);
        end
        @(negedge clk_100);
        checks++;
        if (err_code !== 2'd2 || mmcm_rst !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drdy_to_state: code=%0d rst=%b err=%b busy=%b expected 2 0 0 0",
                     err_code, mmcm_rst, err, busy);
        end
        seen_ready = 1'b0;
        repeat (10) begin
            if (bus.cmd_ready !== 1'b0) seen_ready = 1'b1;
            @(negedge clk_100);
        end
        checks++;
        if (seen_ready !== 1'b0 || rcount !== r0 + 1 || wcount !== w0) begin
            failures++;
            $display("FAIL drdy_to_idle: ready=%b rd=%0d wr=%0d expected 0 1 0",
                     seen_ready, rcount - r0, wcount - w0);
        end
        drdy_en = 1;
        repeat (30) @(negedge clk_100);
    endtask

    task automatic test_lock_timeout;
        int n, c;
        bit ok;
        send_cmd(7'h0B, 16'hFFFF, 16'h0000, 1'b1, ok);
        checks++;
        if (!ok || err_code !== 2'd0) begin
            failures++;
            $display("FAIL lt_start: ok=%0d code=%0d expected 1 0", ok, err_code);
        end
        lock_mode = 1;
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 100) begin
            @(negedge clk_100);
            n++;
        end
        c = cyc;
        n = 0;
        while (err !== 1'b1 && n < 300) begin
            @(negedge clk_100);
            n++;
        end
        checks++;
        if (err !== 1'b1 || cyc - c !== 100) begin
            failures++;
            $display("FAIL lt_time: err=%b after %0d expected 1 after 100", err, cyc - c);
        end
        @(negedge clk_100);
        checks++;
        if (err_code !== 2'd1 || busy !== 1'b0 || mmcm_rst !== 1'b0) begin
            failures++;
            $display("FAIL lt_state: code=%0d busy=%b rst=%b expected 1 0 0",
                     err_code, busy, mmcm_rst);
        end
        lock_mode = 0;
        repeat (30) @(negedge clk_100);
    endtask

    task automatic test_reset_mid_wr;
        int n;
        bit ok;
        drdy_lat = 10;
        send_cmd(7'h0C, 16'hFFFF, 16'h0000, 1'b1, ok);
        n = 0;
        while (!(bus.drp_den === 1'b1 && bus.drp_dwe === 1'b1) && n < 50) begin
            @(negedge clk_100);
            n++;
        end
        checks++;
        if (!ok || bus.drp_dwe !== 1'b1) begin
            failures++;
            $display("FAIL rw_reach_wr: ok=%0d dwe=%b expected 1 1", ok, bus.drp_dwe);
        end
        @(negedge clk_100);
        reset = 1'b1;
        @(negedge clk_100);
        checks++;
        if ({bus.drp_den, bus.drp_dwe, mmcm_rst, busy, bus.cmd_ready} !== 5'b00110 ||
            bus.drp_daddr !== 7'd0 || bus.drp_di !== 16'd0) begin
            failures++;
            $display("FAIL rw_reset: den/dwe/rst/busy/rdy=%b%b%b%b%b daddr=%h expected 00110 00",
                     bus.drp_den, bus.drp_dwe, mmcm_rst, busy, bus.cmd_ready, bus.drp_daddr);
        end
        @(negedge clk_100);
        reset = 1'b0;
        count_rst_high(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL rw_por_len: got %0d expected 16", n);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || cyc !== lock_at + 2) begin
            failures++;
            $display("FAIL rw_done: ok=%0d at %0d expected %0d", ok, cyc, lock_at + 2);
        end
        drdy_lat = 3;
        @(negedge clk_100);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_mask = '0;
        bus.cmd_data = '0;
        bus.cmd_last = 1'b0;
        bus.drp_do = '0;
        bus.drp_drdy = 1'b0;
        test_reset();
        test_por();
        test_rmw();
        test_lock_loss();
        test_lock_drop_wait_cmd();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid_wr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16, giving the number of cycles mmcm_rst is held high per reset pulse (range 2..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, giving the maximum cycles to wait for lock after mmcm_rst is released.
REQ-003 SHALL have parameter DRDY_TIMEOUT, default 255, giving the maximum cycles to wait for drp_drdy after any drp_den.
REQ-004 SHALL have the following ports:
- clk_100  in  1  -- sole clock; also drives the MMCM DCLK.
- reset  in  1  -- synchronous, active-high.
- cmd_valid  in  1  -- reconfiguration command valid.
- cmd_ready  out  1  -- command accepted when cmd_valid and cmd_ready are both high.
- cmd_addr  in  7  -- DRP register address.
- cmd_mask  in  16  -- 1 = keep the existing bit; 0 = replace it from cmd_data.
- cmd_data  in  16  -- new bit values.
- cmd_last  in  1  -- final command of the sequence.
- drp_daddr  out  7  -- DRP address.
- drp_den  out  1  -- DRP enable.
- drp_dwe  out  1  -- DRP write enable.
- drp_di  out  16  -- DRP write data.
- drp_do  in  16  -- DRP read data.
- drp_drdy  in  1  -- DRP ready.
- mmcm_rst  out  1  -- MMCM RST.
- mmcm_locked  in  1  -- MMCM LOCKED; asynchronous to clk_100.
- busy  out  1  -- high in every state except IDLE.
- done  out  1  -- 1-cycle pulse on successful completion.
- err  out  1  -- 1-cycle pulse on failure.
- err_code  out  2  -- 0 none, 1 lock timeout, 2 DRDY timeout; held until the next start.
- locked_sync  out  1  -- synchronised lock status.
- lock_lost  out  1  -- 1-cycle pulse on an unexpected loss of lock.

Function
REQ-005 SHALL pass mmcm_locked through a 2-flop synchroniser to produce locked_sync, with 2-cycle latency.
REQ-006 SHALL implement the states POR_HOLD, IDLE, RST_ASSERT, WAIT_CMD, RD, RD_WAIT, WR, WR_WAIT, RST_HOLD2, WAIT_LOCK.
REQ-007 POR_HOLD SHALL drive mmcm_rst=1 for RST_HOLD cycles, then go to WAIT_LOCK.
REQ-008 In IDLE, cmd_valid=1 SHALL go to RST_ASSERT and SHALL clear err_code. The command is not consumed in IDLE.
REQ-009 RST_ASSERT SHALL drive mmcm_rst=1 for RST_HOLD cycles, then go to WAIT_CMD. mmcm_rst SHALL stay 1 through WAIT_CMD, RD, RD_WAIT, WR and WR_WAIT.
REQ-010 cmd_ready SHALL be 1 only in WAIT_CMD. On acceptance, the block SHALL latch addr, mask, data and last, then go to RD.
REQ-011 RD SHALL drive drp_den=1, drp_dwe=0 and drp_daddr=addr for exactly 1 cycle, then go to RD_WAIT.
REQ-012 RD_WAIT SHALL wait for drp_drdy, capture drp_do, then go to WR.
REQ-013 WR SHALL drive drp_den=1 and drp_dwe=1 for 1 cycle, with drp_di = (captured & mask) | (data & ~mask).
REQ-014 WR_WAIT SHALL wait for drp_drdy, then go to WAIT_LOCK (via mmcm_rst release) if last, else back to WAIT_CMD.
REQ-015 drp_den and drp_dwe SHALL be 0 in all other states.
REQ-016 When last completes, the block SHALL release mmcm_rst=0 and enter WAIT_LOCK.
REQ-017 In WAIT_LOCK, locked_sync=1 SHALL produce a done pulse and a transition to IDLE.
REQ-018 In WAIT_LOCK, if LOCK_TIMEOUT cycles elapse without lock, the block SHALL pulse err, set err_code=1 and go to IDLE.
REQ-019 If drp_drdy does not arrive within DRDY_TIMEOUT cycles in RD_WAIT or WR_WAIT, the block SHALL pulse err, set err_code=2, release mmcm_rst and go to IDLE. No further commands SHALL be consumed.
REQ-020 A drp_drdy arriving outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-021 In IDLE, a 1->0 transition of locked_sync SHALL pulse lock_lost and go to RST_HOLD2.
REQ-022 RST_HOLD2 SHALL drive mmcm_rst=1 for RST_HOLD cycles, then go to WAIT_LOCK. Recovery completion SHALL pulse done.
REQ-023 Lock transitions outside IDLE SHALL NOT pulse lock_lost.
REQ-024 The timeout counter SHALL be one shared counter, cleared on every state entry and saturating at its limit.

Reset
REQ-025 Reset SHALL force POR_HOLD, on any cycle including mid-DRP-transaction, with: mmcm_rst=1, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, cmd_ready=0, busy=1, done=0, err=0, err_code=0, lock_lost=0, synchroniser flops=0, locked_sync=0, counters=0.

Verification
REQ-026 Power-on: release reset with the lock model asserting 20 cycles after mmcm_rst falls -> mmcm_rst high 16 cycles, done after lock +2 cycles, busy=0.
REQ-027 Two-command RMW: DRP regs 0x08=0x1245 and 0x09=0x0080; cmds (0x08, mask 0xF000, data 0x0C3C) and (0x09, mask 0xFF00, data 0x0000, last); drdy latency 3 cycles -> writes 0x1C3C and 0x0000; mmcm_rst high across all four DRP transactions; done after relock.
REQ-028 DRDY timeout: the model never returns drdy on the read -> err pulse exactly 255 cycles after the RD_WAIT entry, err_code=2, mmcm_rst=0, cmd_ready stays 0.
REQ-029 Lock timeout with LOCK_TIMEOUT=100 and the lock held low -> err pulse 100 cycles after release, err_code=1, state IDLE.
REQ-030 Lock loss in IDLE: drop mmcm_locked -> lock_lost pulse 3 cycles later, mmcm_rst high 16 cycles, done after relock. Dropping lock during WAIT_CMD -> no lock_lost pulse.
REQ-031 Reset asserted during WR_WAIT -> drp_den=0 next cycle, mmcm_rst=1, and the POR sequence restarts.
